// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and widths for the MAC sequencer
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } mac_state_t;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 35;

endpackage

// File: rtl/mac_lat_pipe.sv
// rtl/mac_lat_pipe.sv - LAT-deep delay of mul_vld that becomes acc_en
module mac_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic vld_in,
    output logic vld_out
);

    logic [LAT-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= vld_in;
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign vld_out = sr[LAT-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer for the 16-bit MAC datapath
// Optional MAC_OVF_FLAG_EN registers res_ovf from the accumulator upper bits.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              op_ready,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_vld,
    output logic              acc_clr,
    output logic              acc_en,
    input  logic [ACC_W-1:0]  acc_out,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    input  logic              res_ready
);

    localparam int DW = $clog2(MUL_LAT + 2) + 1;
    // DRAIN spans MUL_LAT+2 cycles so the last product has landed in acc_out
    localparam logic [DW-1:0] DLAST = DW'(MUL_LAT + 1);

    mac_state_t       state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    dcnt;
    logic             hs;
    logic             capture;

    assign hs      = op_valid && op_ready;
    assign capture = (state == DRAIN) && (dcnt == DLAST);

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (cnt != '0) ? RUN : DRAIN;
            RUN:     if (hs && cnt == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (capture) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        op_ready  = (state == RUN);
        acc_clr   = (state == CLEAR);
        res_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt      <= '0;
            dcnt     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_vld  <= 1'b0;
            res_data <= '0;
        end else begin
            mul_vld <= hs;
            if (state == IDLE && start) begin
                cnt <= len;
            end else if (hs) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (hs) begin
                mul_a <= op_a;
                mul_b <= op_b;
            end
            dcnt <= (state == DRAIN) ? dcnt + DW'(1) : '0;
            if (capture) res_data <= acc_out;
        end
    end

`ifdef MAC_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (clr)          ovf_q <= 1'b0;
        else if (capture) ovf_q <= |acc_out[ACC_W-1:PROD_W];
    end

    assign res_ovf = ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    mac_lat_pipe #(.LAT(MUL_LAT)) u_lat_pipe (
        .clk     (clk),
        .clr     (clr),
        .vld_in  (mul_vld),
        .vld_out (acc_en)
    );

endmodule
